// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/REQ/RESP handshake to a word-addressed memory with lane steering,
// load extension, a 16-cycle timeout and reset abort. Macro LSU_MISALIGN_TRAP_EN traps unaligned half/word accesses.
module load_store_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        MEM_WE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ALU_Salida,
  input  logic [31:0] RS2_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        MISALIGN,
  output logic [31:0] LOAD_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WR,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      r_state;
  logic [5:0]  r_wait_cnt;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic        r_busy, r_done, r_err, r_misalign;
  logic [31:0] r_load_data;
  logic        r_mem_req, r_mem_wr;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        w_invalid, w_misaligned, w_trap;
  logic [1:0]  w_offset;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  // Request decode on the execute-stage inputs, used only at the START capture.
  assign w_invalid    = (FUNCT3 == 3'b011) || (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111);
  assign w_misaligned = ((FUNCT3[1:0] == 2'b01) && ALU_Salida[0]) ||
                        ((FUNCT3[1:0] == 2'b10) && (ALU_Salida[1:0] != 2'b00));
  // An unaligned half/word that is allowed to proceed falls back to lane 0.
  assign w_offset     = w_misaligned ? 2'b00 : ALU_Salida[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = RS2_DATA;
    if (MEM_WE) begin
      case (FUNCT3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_offset;
          w_wdata = {4{RS2_DATA[7:0]}};
        end
        2'b01: begin
          w_be    = w_offset[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{RS2_DATA[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_shifted = MEM_RDATA >> {r_offset, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_offset[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'b0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'b0, w_half};
      default: w_load_ext = MEM_RDATA;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_is_store  <= 1'b0;
      r_funct3    <= '0;
      r_offset    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_misalign  <= 1'b0;
      r_load_data <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_is_store <= MEM_WE;
            r_funct3   <= FUNCT3;
            r_offset   <= w_offset;
            r_busy     <= 1'b1;
            if (w_invalid) begin
              r_state <= RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_trap) begin
              r_state    <= RESP;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state     <= REQ;
              r_wait_cnt  <= '0;
              r_mem_req   <= 1'b1;
              r_mem_wr    <= MEM_WE;
              r_mem_addr  <= {ALU_Salida[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        REQ: begin
          if (MEM_ACK) begin
            r_state   <= RESP;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            if (!r_is_store) r_load_data <= w_load_ext;
          end else if (r_wait_cnt == 6'd15) begin
            // Sixteenth unanswered request cycle: give up with an error.
            r_wait_cnt <= 6'd16;
            r_state    <= RESP;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_wr   <= 1'b0;
            if (!r_is_store) r_load_data <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 6'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign MISALIGN  = r_misalign;
  assign LOAD_DATA = r_load_data;
  assign MEM_REQ   = r_mem_req;
  assign MEM_WR    = r_mem_wr;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign MEM_BE    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (default build, trap macro undefined).
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST, START, MEM_WE, MEM_ACK;
  logic [2:0]  FUNCT3;
  logic [31:0] ALU_Salida, RS2_DATA, MEM_RDATA;
  logic        BUSY, DONE, ERR, MISALIGN, MEM_REQ, MEM_WR;
  logic [31:0] LOAD_DATA, MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_BE;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req, n_done;

  load_store_unit dut (
    .CLK(CLK), .RST(RST), .START(START), .MEM_WE(MEM_WE), .FUNCT3(FUNCT3),
    .ALU_Salida(ALU_Salida), .RS2_DATA(RS2_DATA), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .MISALIGN(MISALIGN), .LOAD_DATA(LOAD_DATA), .MEM_REQ(MEM_REQ),
    .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one edge; returns in cycle 1 of the access.
  task automatic start_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data);
    START = 1'b1; MEM_WE = we; FUNCT3 = f3; ALU_Salida = addr; RS2_DATA = data;
    tick();
    START = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; MEM_WE = 1'b0; MEM_ACK = 1'b0; FUNCT3 = 3'b000;
    ALU_Salida = '0; RS2_DATA = '0; MEM_RDATA = '0;
    tick(); tick();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_req", MEM_REQ, 0);
    check("rst_be", MEM_BE, 0);
    check("rst_addr", MEM_ADDR, 0);
    check("rst_load", LOAD_DATA, 0);
    RST = 1'b0;

    // ACK while idle is ignored
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("idle_ack_busy", BUSY, 0);
    check("idle_ack_done", DONE, 0);

    // Store word, ACK in cycle 2, DONE in cycle 3
    start_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    check("sw_req_c1", MEM_REQ, 1);
    check("sw_busy_c1", BUSY, 1);
    check("sw_wr", MEM_WR, 1);
    check("sw_addr", MEM_ADDR, 32'h100);
    check("sw_be", MEM_BE, 4'b1111);
    check("sw_wdata", MEM_WDATA, 32'hDEADBEEF);
    tick();
    check("sw_req_c2", MEM_REQ, 1);
    check("sw_done_c2", DONE, 0);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("sw_done_c3", DONE, 1);
    check("sw_err", ERR, 0);
    check("sw_req_c3", MEM_REQ, 0);
    check("sw_load_keep", LOAD_DATA, 0);
    tick();
    check("sw_done_c4", DONE, 0);
    check("sw_busy_c4", BUSY, 0);

    // Load byte signed
    MEM_RDATA = 32'h000080FF;
    start_op(1'b0, 3'b000, 32'hF0206055, 32'h0);
    check("lb_addr", MEM_ADDR, 32'hF0206054);
    check("lb_be", MEM_BE, 4'b1111);
    check("lb_wr", MEM_WR, 0);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("lb_done", DONE, 1);
    check("lb_data", LOAD_DATA, 32'hFFFFFF80);
    tick();

    // Load byte unsigned
    start_op(1'b0, 3'b100, 32'hF0206055, 32'h0);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("lbu_done", DONE, 1);
    check("lbu_data", LOAD_DATA, 32'h00000080);
    tick();

    // Unaligned half falls back to the lower half
    MEM_RDATA = 32'h12348765;
    start_op(1'b0, 3'b001, 32'h103, 32'h0);
    check("lh_un_addr", MEM_ADDR, 32'h100);
    check("lh_un_req", MEM_REQ, 1);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("lh_un_done", DONE, 1);
    check("lh_un_mis", MISALIGN, 0);
    check("lh_un_data", LOAD_DATA, 32'hFFFF8765);
    tick();

    // Aligned unsigned half, upper lane
    start_op(1'b0, 3'b101, 32'h102, 32'h0);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("lhu_data", LOAD_DATA, 32'h00001234);
    tick();

    // Store byte to lane 3
    start_op(1'b1, 3'b000, 32'h203, 32'h000000A5);
    check("sb_addr", MEM_ADDR, 32'h200);
    check("sb_be", MEM_BE, 4'b1000);
    check("sb_wdata", MEM_WDATA, 32'hA5A5A5A5);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    tick();

    // Store half to upper lanes; LOAD_DATA untouched
    start_op(1'b1, 3'b001, 32'h202, 32'h1111BEEF);
    check("sh_be", MEM_BE, 4'b1100);
    check("sh_wdata", MEM_WDATA, 32'hBEEFBEEF);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("sh_done", DONE, 1);
    check("sh_load_keep", LOAD_DATA, 32'h00001234);
    tick();

    // Invalid FUNCT3 completes next cycle with ERR
    start_op(1'b0, 3'b011, 32'h300, 32'h0);
    check("inv_done", DONE, 1);
    check("inv_err", ERR, 1);
    check("inv_req", MEM_REQ, 0);
    check("inv_busy", BUSY, 1);
    tick();
    check("inv_done_off", DONE, 0);
    check("inv_busy_off", BUSY, 0);

    // Timeout: 16 request cycles, then DONE with ERR and LOAD_DATA cleared
    start_op(1'b0, 3'b010, 32'h300, 32'h0);
    n_req = 0;
    for (int i = 0; i < 16; i++) begin
      if (MEM_REQ) n_req++;
      tick();
    end
    check("to_req_cycles", n_req, 16);
    check("to_req_off", MEM_REQ, 0);
    check("to_done", DONE, 1);
    check("to_err", ERR, 1);
    check("to_load", LOAD_DATA, 32'h0);
    tick();

    // Reset in REQ cycle 3 aborts with no DONE
    start_op(1'b0, 3'b010, 32'h400, 32'h0);
    tick(); tick();
    check("abort_req_c3", MEM_REQ, 1);
    RST = 1'b1; tick(); RST = 1'b0;
    check("abort_req", MEM_REQ, 0);
    check("abort_busy", BUSY, 0);
    check("abort_be", MEM_BE, 0);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (DONE) n_done++;
      tick();
    end
    check("abort_no_done", n_done, 0);
    MEM_RDATA = 32'hCAFEF00D;
    start_op(1'b0, 3'b010, 32'h400, 32'h0);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    check("post_abort_done", DONE, 1);
    check("post_abort_data", LOAD_DATA, 32'hCAFEF00D);
    tick();

    // START while BUSY is ignored; exactly one DONE
    MEM_RDATA = 32'h0BADC0DE;
    start_op(1'b0, 3'b010, 32'h500, 32'h0);
    START = 1'b1; MEM_WE = 1'b1; ALU_Salida = 32'h600; tick(); START = 1'b0;
    check("busy_start_addr", MEM_ADDR, 32'h500);
    check("busy_start_wr", MEM_WR, 0);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (DONE) n_done++;
      tick();
    end
    check("busy_one_done", n_done, 1);
    check("busy_data", LOAD_DATA, 32'h0BADC0DE);
    check("busy_idle", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 CLK  input  1  single clock; all state SHALL update on the rising edge only.
REQ-002 RST  input  1  reset; SHALL be synchronous and active-high.
REQ-003 START  input  1  SHALL be a one-cycle request from the execute stage to begin an access.
REQ-004 MEM_WE  input  1  SHALL select a store when 1 and a load when 0.
REQ-005 FUNCT3  input  3  SHALL encode the access size: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-006 ALU_Salida  input  32  SHALL carry the effective byte address, i.e. the ALU result.
REQ-007 RS2_DATA  input  32  SHALL carry the store data.
REQ-008 BUSY  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-009 DONE  output  1  SHALL pulse high for one cycle when an access completes.
REQ-010 ERR  output  1  SHALL be valid only with DONE and flag a timeout or an invalid FUNCT3.
REQ-011 MISALIGN  output  1  SHALL be valid only with DONE and flag an unaligned access.
REQ-012 LOAD_DATA  output  32  SHALL hold the extended load result, valid with DONE and held until the next DONE.
REQ-013 MEM_REQ, MEM_WR  output  1 each  SHALL carry the memory request and its write qualifier.
REQ-014 MEM_ADDR  output  32  SHALL be the word address, with bits [1:0] always 0.
REQ-015 MEM_WDATA  output  32, MEM_BE  output  4  SHALL carry the lane-aligned store data and byte enables.
REQ-016 MEM_RDATA  input  32, MEM_ACK  input  1  SHALL carry the memory read data and completion.

Function
REQ-017 FSM SHALL have the states IDLE, REQ and RESP.
REQ-018 In IDLE, START SHALL capture MEM_WE, FUNCT3, ALU_Salida and RS2_DATA and move the FSM to REQ.
REQ-019 START SHALL be ignored while BUSY=1.
REQ-020 In REQ, MEM_REQ SHALL be 1 and all memory outputs SHALL be stable until MEM_ACK.
REQ-021 MEM_ACK=1 in REQ SHALL register MEM_RDATA and move the FSM to RESP.
REQ-022 MEM_ACK outside REQ SHALL be ignored.
REQ-023 RESP SHALL assert DONE for one cycle and return the FSM to IDLE.
REQ-024 With START at cycle 0 and MEM_ACK at cycle k≥1, MEM_REQ SHALL be high in cycles 1..k and DONE SHALL be high in cycle k+1.
REQ-025 Stores SHALL drive MEM_BE as follows:
- byte: 1<<addr[1:0], with the byte replicated on all lanes;
- half: 0011 or 1100 selected by addr[1], with the half replicated;
- word: 1111.
REQ-026 Loads SHALL drive MEM_BE as 1111, select the addressed lane, and sign-extend (000/001) or zero-extend (100/101) it.
REQ-027 A 6-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without MEM_ACK.
REQ-028 When the wait counter reaches 16, the block SHALL drop MEM_REQ, go to RESP, and assert DONE with ERR=1 and LOAD_DATA=0.
REQ-029 FUNCT3 values 011, 110 and 111 SHALL skip REQ and complete in the next cycle with DONE and ERR=1.
REQ-030 For stores, LOAD_DATA SHALL remain unchanged.

Reset
REQ-031 RST SHALL force the following at the next edge, including in the middle of an access:
- state=IDLE;
- MEM_REQ, MEM_WR, DONE, ERR, MISALIGN, BUSY = 0;
- MEM_ADDR, MEM_WDATA, LOAD_DATA = 0;
- MEM_BE = 0000;
- wait counter = 0.
REQ-032 An aborted access SHALL produce no DONE.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN SHALL control the handling of unaligned half and word accesses.
- Defined: an unaligned half or word access SHALL issue no MEM_REQ and complete the next cycle with DONE=1 and MISALIGN=1.
- Undefined: MISALIGN SHALL be tied to 0, and the access SHALL proceed using addr[1:0] forced to the natural alignment.

Verification
REQ-034 Store: START, MEM_WE=1, FUNCT3=010, ALU_Salida=0x100, RS2_DATA=0xDEADBEEF, ACK on cycle 2 -> MEM_ADDR=0x100, MEM_BE=1111, MEM_WDATA=0xDEADBEEF, DONE in cycle 3.
REQ-035 Load byte: ALU_Salida=0xF0206055, FUNCT3=000, MEM_RDATA=0x000080FF -> MEM_ADDR=0xF0206054, LOAD_DATA=0xFFFFFF80; same with FUNCT3=100 -> LOAD_DATA=0x00000080.
REQ-036 Unaligned half: FUNCT3=001, ALU_Salida=0x103.
- With the macro: no MEM_REQ, DONE=1 and MISALIGN=1 at cycle 1.
- Without the macro: MEM_ADDR=0x100, lower half selected.
REQ-037 Timeout: MEM_ACK held 0 -> MEM_REQ high for 16 cycles, then DONE=1, ERR=1, LOAD_DATA=0.
REQ-038 RST asserted in REQ cycle 3 -> MEM_REQ=0 and BUSY=0 the next cycle, no DONE; a later START with ACK completes normally.
REQ-039 START pulsed while BUSY -> ignored; exactly one DONE.
